// File: rtl/delivery_game_uc.sv
// Control unit for the delivery game: clears the datapath, takes the initial
// velocity measurement, scrolls the map, periodically re-measures velocity,
// and handles pause and game over.
module delivery_game_uc #(
  parameter int REMEASURE_PERIOD = 500_000,
  parameter int MEASURE_TIMEOUT  = 50_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       pausar,
  input  logic       game_over,
  input  logic       velocity_ready,
  output logic       zera_fd,
  output logic       get_velocity,
  output logic       count_map,
  output logic       jogando,
  output logic       fim_jogo,
  output logic       falha_sensor,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    PREPARA   = 4'd1,
    MEDE      = 4'd2,
    ESPERA    = 4'd3,
    JOGANDO   = 4'd4,
    RE_MEDE   = 4'd5,
    RE_ESPERA = 4'd6,
    PAUSADO   = 4'd7,
    FIM       = 4'd8
  } state_t;

  // Last counter values before the period / timeout expires (equality compare).
  localparam logic [31:0] PERIOD_LAST  = 32'(REMEASURE_PERIOD - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(MEASURE_TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic        iniciar_prev_reg;
  logic        iniciar_rise;
  logic [31:0] period_count_reg, period_count_next;
  logic [31:0] timeout_count_reg, timeout_count_next;
  logic        falha_sensor_reg, falha_sensor_next;

  assign iniciar_rise = iniciar & ~iniciar_prev_reg;

  // State, counters, sticky failure flag and iniciar history.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg         <= INICIAL;
      iniciar_prev_reg  <= 1'b0;
      period_count_reg  <= '0;
      timeout_count_reg <= '0;
      falha_sensor_reg  <= 1'b0;
    end else begin
      state_reg         <= state_next;
      iniciar_prev_reg  <= iniciar;
      period_count_reg  <= period_count_next;
      timeout_count_reg <= timeout_count_next;
      falha_sensor_reg  <= falha_sensor_next;
    end
  end

  // Next-state, counter updates and Moore outputs decoded from the state.
  always_comb begin
    state_next         = state_reg;
    period_count_next  = period_count_reg;
    timeout_count_next = timeout_count_reg;
    falha_sensor_next  = falha_sensor_reg;
    zera_fd            = 1'b0;
    get_velocity       = 1'b0;
    count_map          = 1'b0;
    jogando            = 1'b0;
    fim_jogo           = 1'b0;

    case (state_reg)
      INICIAL: begin
        if (iniciar_rise) state_next = PREPARA;
      end

      PREPARA: begin
        zera_fd            = 1'b1;
        period_count_next  = '0;
        timeout_count_next = '0;
        falha_sensor_next  = 1'b0;
        state_next         = MEDE;
      end

      MEDE: begin
        get_velocity = 1'b1;
        state_next   = ESPERA;
      end

      ESPERA: begin
        timeout_count_next = timeout_count_reg + 32'd1;
        if (velocity_ready) begin
          falha_sensor_next = 1'b0;
          state_next        = JOGANDO;
        end else if (timeout_count_reg == TIMEOUT_LAST) begin
          falha_sensor_next = 1'b1;
          state_next        = JOGANDO;
        end
      end

      JOGANDO: begin
        count_map = 1'b1;
        jogando   = 1'b1;
        if (game_over) begin
          state_next = FIM;
        end else if (pausar) begin
          // The cycle that requests the pause is not counted as play time.
          state_next = PAUSADO;
        end else begin
          period_count_next = period_count_reg + 32'd1;
          if (period_count_reg == PERIOD_LAST) state_next = RE_MEDE;
        end
      end

      RE_MEDE: begin
        count_map          = 1'b1;
        get_velocity       = 1'b1;
        jogando            = 1'b1;
        period_count_next  = '0;
        timeout_count_next = '0;
        state_next         = game_over ? FIM : RE_ESPERA;
      end

      RE_ESPERA: begin
        count_map          = 1'b1;
        jogando            = 1'b1;
        timeout_count_next = timeout_count_reg + 32'd1;
        if (game_over) begin
          state_next = FIM;
        end else if (velocity_ready) begin
          falha_sensor_next = 1'b0;
          state_next        = JOGANDO;
        end else if (timeout_count_reg == TIMEOUT_LAST) begin
          falha_sensor_next = 1'b1;
          state_next        = JOGANDO;
        end
      end

      PAUSADO: begin
        if (game_over)    state_next = FIM;
        else if (!pausar) state_next = JOGANDO;
      end

      FIM: begin
        fim_jogo = 1'b1;
        if (iniciar_rise) state_next = PREPARA;
      end

      default: begin
        state_next = INICIAL;
      end
    endcase
  end

  assign falha_sensor = falha_sensor_reg;
  assign db_estado    = state_reg;

endmodule

// File: tb/tb_delivery_game_uc.sv
// Self-checking bench for delivery_game_uc: directed scenarios with literal
// expectations plus randomized play, all compared every cycle to a model.
module tb_delivery_game_uc;

  localparam int RP = 20;
  localparam int MT = 10;

  logic       clock, reset;
  logic       iniciar, pausar, game_over, velocity_ready;
  logic       zera_fd, get_velocity, count_map, jogando, fim_jogo, falha_sensor;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  delivery_game_uc #(
    .REMEASURE_PERIOD(RP),
    .MEASURE_TIMEOUT (MT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .iniciar       (iniciar),
    .pausar        (pausar),
    .game_over     (game_over),
    .velocity_ready(velocity_ready),
    .zera_fd       (zera_fd),
    .get_velocity  (get_velocity),
    .count_map     (count_map),
    .jogando       (jogando),
    .fim_jogo      (fim_jogo),
    .falha_sensor  (falha_sensor),
    .db_estado     (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: game phase plus "unpaused play cycles since last
  // measurement" and "cycles spent waiting for the sensor".
  int   m_st;
  logic m_prev;
  int   m_play;
  int   m_wait;
  logic m_fail;

  always @(posedge clock or posedge reset) begin : model
    int   s, play, wt;
    logic fail, rise;
    if (reset) begin
      m_st   <= 0;
      m_prev <= 1'b0;
      m_play <= 0;
      m_wait <= 0;
      m_fail <= 1'b0;
    end else begin
      s    = m_st;
      play = m_play;
      wt   = m_wait;
      fail = m_fail;
      rise = iniciar && !m_prev;
      case (m_st)
        0: if (rise) s = 1;
        1: begin play = 0; wt = 0; fail = 1'b0; s = 2; end
        2: s = 3;
        3: begin
          wt = wt + 1;
          if (velocity_ready) begin fail = 1'b0; s = 4; end
          else if (wt == MT)  begin fail = 1'b1; s = 4; end
        end
        4: begin
          if (game_over)   s = 8;
          else if (pausar) s = 7;
          else begin
            play = play + 1;
            if (play == RP) s = 5;
          end
        end
        5: begin play = 0; wt = 0; s = game_over ? 8 : 6; end
        6: begin
          if (game_over) s = 8;
          else begin
            wt = wt + 1;
            if (velocity_ready) begin fail = 1'b0; s = 4; end
            else if (wt == MT)  begin fail = 1'b1; s = 4; end
          end
        end
        7: begin
          if (game_over)    s = 8;
          else if (!pausar) s = 4;
        end
        8: if (rise) s = 1;
        default: s = 0;
      endcase
      m_st   <= s;
      m_play <= play;
      m_wait <= wt;
      m_fail <= fail;
      m_prev <= iniciar;
    end
  end

  function automatic logic [9:0] expected_vec(int s, logic f);
    logic [3:0] code;
    code = 4'(s);
    return {code, s == 1, (s == 2) || (s == 5), (s >= 4) && (s <= 6),
            (s >= 4) && (s <= 6), s == 8, f};
  endfunction

  // Every-cycle comparison of all outputs against the model, mid-cycle.
  always @(negedge clock) begin : compare
    logic [9:0] act, exp;
    cycle = cycle + 1;
    act = {db_estado, zera_fd, get_velocity, count_map, jogando, fim_jogo, falha_sensor};
    exp = expected_vec(m_st, m_fail);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL cycle_check cycle=%0d {st,zera,gv,cmap,jog,fim,falha} got=%b expected=%b",
               cycle, act, exp);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b0; pausar = 1'b0; game_over = 1'b0; velocity_ready = 1'b0;
    tick(2);
    reset = 1'b0;
    check("reset_state", db_estado, 0);
    check("reset_outputs", {zera_fd, get_velocity, count_map, jogando, fim_jogo, falha_sensor}, 0);

    // Start with ready 3 cycles after get_velocity
    iniciar = 1'b1; tick();
    check("prepara_state", db_estado, 1);
    check("prepara_zera", zera_fd, 1);
    iniciar = 1'b0; tick();
    check("mede_state", db_estado, 2);
    check("mede_getvel", {zera_fd, get_velocity}, 2'b01);
    tick();
    check("espera_state", db_estado, 3);
    check("espera_getvel_low", get_velocity, 0);
    tick(2);
    velocity_ready = 1'b1; tick(); velocity_ready = 1'b0;
    check("first_play_state", db_estado, 4);
    check("first_play_cmap_falha", {count_map, falha_sensor}, 2'b10);

    // Game over in JOGANDO, then start with no ready (timeout)
    game_over = 1'b1; tick(); game_over = 1'b0;
    check("go_jogando_fim", {db_estado, fim_jogo}, {4'd8, 1'b1});
    iniciar = 1'b1; tick(); iniciar = 1'b0; tick(); tick();
    tick(9);
    check("espera_10th_cycle", db_estado, 3);
    tick();
    check("timeout_play", {db_estado, falha_sensor}, {4'd4, 1'b1});

    // Re-measure after 20 play cycles; ready clears failure
    tick(19);
    check("play_20th_cycle", db_estado, 4);
    tick();
    check("re_mede", {db_estado, count_map, get_velocity}, {4'd5, 2'b11});
    tick();
    check("re_espera", {db_estado, count_map}, {4'd6, 1'b1});
    velocity_ready = 1'b1; tick(); velocity_ready = 1'b0;
    check("remeasure_ok", {db_estado, falha_sensor}, {4'd4, 1'b0});

    // Pause 15 cycles after 5 counted play cycles
    tick(5);
    pausar = 1'b1; tick();
    check("paused", {db_estado, count_map}, {4'd7, 1'b0});
    tick(14);
    check("still_paused", db_estado, 7);
    pausar = 1'b0; tick();
    check("resume", db_estado, 4);
    tick(14);
    check("resume_15th_cycle", db_estado, 4);
    tick();
    check("re_mede_after_pause", db_estado, 5);

    // Game over in RE_ESPERA while iniciar rises and is then held
    tick();
    game_over = 1'b1; iniciar = 1'b1; tick(); game_over = 1'b0;
    check("go_re_espera_fim", {db_estado, fim_jogo}, {4'd8, 1'b1});
    tick(3);
    check("held_iniciar_no_restart", db_estado, 8);
    iniciar = 1'b0; tick(); iniciar = 1'b1; tick(); iniciar = 1'b0;
    check("restart_edge", db_estado, 1);

    // Game over in PAUSADO
    tick(2);
    velocity_ready = 1'b1; tick(); velocity_ready = 1'b0;
    pausar = 1'b1; tick();
    game_over = 1'b1; tick(); game_over = 1'b0; pausar = 1'b0;
    check("go_pausado_fim", {db_estado, fim_jogo}, {4'd8, 1'b1});

    // Asynchronous reset mid-RE_ESPERA
    iniciar = 1'b1; tick(); iniciar = 1'b0; tick(2);
    velocity_ready = 1'b1; tick(); velocity_ready = 1'b0;
    tick(RP + 1);
    check("before_reset_re_espera", db_estado, 6);
    reset = 1'b1; #1;
    check("async_reset_state", db_estado, 0);
    check("async_reset_outputs",
          {zera_fd, get_velocity, count_map, jogando, fim_jogo, falha_sensor}, 0);
    tick(); reset = 1'b0;

    // Randomized play against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) iniciar = ~iniciar;
      if ($urandom_range(0, 11) == 0) pausar = ~pausar;
      game_over      = ($urandom_range(0, 59) == 0);
      velocity_ready = ($urandom_range(0, 7) == 0);
      reset          = ($urandom_range(0, 999) == 0);
      tick();
    end
    reset = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/delivery_game_uc.md
# delivery_game_uc

Control unit that sequences the delivery game datapath. It clears the datapath, takes the initial ultrasonic velocity measurement, and then runs the map scroll. During play it periodically re-measures velocity, handles pause, and halts scrolling on game over. It sits beside the datapath: it drives `zera_fd`, `count_map` and `get_velocity`, and consumes `game_over` and `velocity_ready`.

## Interface
- `REMEASURE_PERIOD`, default 500_000: JOGANDO cycles between velocity re-measurements (≥2).
- `MEASURE_TIMEOUT`, default 50_000: maximum cycles spent waiting for `velocity_ready` (≥2).
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `iniciar` in 1: start/restart request. Rising-edge detected internally; the previous-value register resets to 0.
- `pausar` in 1: level. While high in JOGANDO or PAUSADO, the game is paused.
- `game_over` in 1: collision flag from the datapath (level).
- `velocity_ready` in 1: measurement done from the ultrasonic interface (level or pulse).
- `zera_fd` out 1: synchronous clear to the datapath.
- `get_velocity` out 1: one-cycle measurement request.
- `count_map` out 1: enables map scrolling.
- `jogando` out 1: high in JOGANDO, RE_MEDE, RE_ESPERA.
- `fim_jogo` out 1: high in FIM.
- `falha_sensor` out 1: sticky measurement-timeout flag.
- `db_estado` out 4: current state code.

## Operation
All outputs are Moore, decoded from the registered state. `falha_sensor` is a separate register.

States and codes:
- INICIAL 0: all outputs 0. Goes to PREPARA on an `iniciar` rising edge.
- PREPARA 1: `zera_fd`=1. Clears the period counter, timeout counter and `falha_sensor`. Goes to MEDE unconditionally.
- MEDE 2: `get_velocity`=1. Goes to ESPERA unconditionally. `velocity_ready` is ignored here.
- ESPERA 3: outputs 0, timeout counter increments.
  - `velocity_ready`=1 goes to JOGANDO.
  - Otherwise, timeout counter = `MEASURE_TIMEOUT`-1 sets `falha_sensor` and goes to JOGANDO.
- JOGANDO 4: `count_map`=1, period counter increments. Priority order:
  - `game_over` goes to FIM.
  - `pausar` goes to PAUSADO.
  - Period counter = `REMEASURE_PERIOD`-1 goes to RE_MEDE.
- RE_MEDE 5: `count_map`=1, `get_velocity`=1. Clears the period counter and timeout counter.
  - `game_over` goes to FIM; otherwise goes to RE_ESPERA.
- RE_ESPERA 6: `count_map`=1, timeout counter increments. Priority order:
  - `game_over` goes to FIM.
  - `velocity_ready` clears `falha_sensor` and goes to JOGANDO.
  - Timeout counter = `MEASURE_TIMEOUT`-1 sets `falha_sensor` and goes to JOGANDO.
- PAUSADO 7: outputs 0, period counter frozen.
  - `game_over` goes to FIM.
  - `pausar`=0 goes to JOGANDO.
- FIM 8: `fim_jogo`=1. An `iniciar` rising edge goes to PREPARA. Holding `iniciar` high does not restart.

Rules:
- Codes 9–15 are illegal and go to INICIAL on the next clock.
- Counters are 32-bit unsigned. They compare with equality and never wrap in practice, because they are cleared on state entry.
- `pausar` is ignored in RE_MEDE and RE_ESPERA. It takes effect on return to JOGANDO.
- Successful first measurement (ESPERA) also clears `falha_sensor`. It is already 0 from PREPARA.

## Timing
- Reset: state INICIAL. `db_estado`=0 and all outputs 0, immediately (asynchronous).
- `iniciar` edge sampled at clock edge n:
  - state PREPARA after edge n, so `zera_fd` is high for exactly one cycle.
  - `get_velocity` is high for the following cycle.
  - ESPERA after that.
- `velocity_ready` sampled high in ESPERA at edge m gives `count_map`=1 from edge m onward.
- Timeout: ESPERA lasts exactly `MEASURE_TIMEOUT` cycles when no ready arrives. `falha_sensor` rises together with entry into JOGANDO.
- Re-measure: RE_MEDE is entered after exactly `REMEASURE_PERIOD` JOGANDO cycles. Paused cycles are not counted.
- `game_over` sampled high: FIM on the next edge, so `count_map` drops with a 1-cycle latency.
- Reset mid-operation: immediate return to INICIAL from any state; counters and `falha_sensor` cleared.

## Test plan
Bench parameters: `REMEASURE_PERIOD`=20, `MEASURE_TIMEOUT`=10.

- Reset, then pulse `iniciar`, with `velocity_ready` 3 cycles after `get_velocity`.
  - `db_estado` goes 0→1→2→3→4.
  - `zera_fd` and `get_velocity` each high for one cycle.
  - `count_map`=1 and `falha_sensor`=0.
- Start with no `velocity_ready`.
  - ESPERA for 10 cycles, then JOGANDO with `falha_sensor`=1.
- Run in JOGANDO.
  - RE_MEDE after 20 cycles with `count_map` staying 1.
  - A ready in RE_ESPERA returns to JOGANDO and clears `falha_sensor`.
- In JOGANDO, raise `pausar` for 15 cycles at count 5.
  - PAUSADO with `count_map`=0.
  - After release, RE_MEDE after 15 more JOGANDO cycles.
- Raise `game_over` in JOGANDO, in RE_ESPERA, and in PAUSADO.
  - Each goes to FIM next cycle with `fim_jogo`=1.
  - Holding `iniciar` high does not restart; a new rising edge goes to PREPARA.
- Assert `reset` mid-RE_ESPERA.
  - `db_estado`=0 and all outputs 0 asynchronously.
